cadence_meter: RTL and testbench
================================

CADENCE_METER -- requirements
Module: cadence_meter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent blip channels, 1..8.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 100_000_000: gate window length in clk50M cycles (2 s).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50_000: stability time in cycles (1 ms); 0 bypasses the debounce.
REQ-004 SHALL have parameter CNT_W, default 8: width of each per-window blip count.
REQ-005 SHALL have parameter PERIOD_W, default 27: width of each blip-to-blip period measurement.
REQ-006 SHALL have port clk50M, input, 1: the single clock, rising-edge; all logic is in this domain.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port Enable, input, 1: high runs the gate timer; low freezes all counters and outputs.
REQ-009 SHALL have port Blips, input, NUM_CH: raw asynchronous sensor pulses, one bit per channel.
REQ-010 SHALL have port CountOut, output, NUM_CH*CNT_W: debounced rising edges counted in the last complete window, channel 0 in the LSBs.
REQ-011 SHALL have port PeriodOut, output, NUM_CH*PERIOD_W: cycles between the last two accepted edges, per channel.
REQ-012 SHALL have port Active, output, NUM_CH: high while the channel has seen an edge within the last WINDOW_CYCLES cycles.
REQ-013 SHALL have port Update, output, 1: one-cycle strobe marking the cycle CountOut is refreshed.

Function
REQ-014 Each Blips bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced level SHALL take the synchronized value on the cycle after that value has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the stability count.
REQ-016 An accepted edge SHALL be a 0->1 transition of the debounced level, asserted for exactly one cycle.
REQ-017 The gate timer SHALL count 0..WINDOW_CYCLES-1 and wrap; the wrap cycle is the terminal cycle.
REQ-018 On the terminal cycle, each CountOut lane SHALL load its running count plus any edge in that same cycle, the running count SHALL clear to 0, and Update SHALL assert on the following cycle, aligned with the new CountOut.
REQ-019 Running counts SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 The per-channel period counter SHALL increment every enabled cycle and saturate at 2^PERIOD_W-1.
REQ-021 On an edge, PeriodOut SHALL load the counter value +1 (saturated), and the counter SHALL restart at 0.
REQ-022 The first edge after reset SHALL only restart the period counter and SHALL leave PeriodOut at 0.
REQ-023 Active SHALL set on an edge; it SHALL clear after WINDOW_CYCLES enabled cycles with no edge, and PeriodOut SHALL hold its value when Active clears.
REQ-024 With Enable low, the timer, counts, period counters, timeout counters and debounce counters SHALL hold, edges SHALL be ignored, Update SHALL stay 0, the synchronizers SHALL keep running, and outputs SHALL hold.
REQ-025 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be counted in the same cycle.

Reset
REQ-026 On reset_n low, the following SHALL clear to 0 asynchronously: all outputs, the synchronizers, the debounced levels, and all counters.
REQ-027 Reset deassertion mid-window SHALL start a fresh window at timer 0, and no Update SHALL assert for partial data.

Structure
REQ-028 A shared package cadence_pkg SHALL hold the default parameter constants and the per-channel status struct (count, period, active).
REQ-029 The per-channel logic SHALL be one sub-module, cadence_channel, covering sync, debounce, edge detect, counting, period and timeout, instantiated NUM_CH times by generate.
REQ-030 The gate timer and Update SHALL reside once in cadence_meter; each channel SHALL receive a terminal-cycle strobe from it.

Verification
REQ-031 With WINDOW_CYCLES=100 and DEBOUNCE_CYCLES=4, 5 clean pulses on channel 0 within one window SHALL give CountOut[0]=5 with Update one cycle after the terminal cycle, and channel 1 SHALL read 0.
REQ-032 A glitch of 3 cycles SHALL not be counted; a pulse high for 5 or more cycles SHALL be counted once.
REQ-033 With CNT_W=3, 10 pulses in one window SHALL give CountOut=7 (saturated), and the next window SHALL restart from 0.
REQ-034 Edges spaced 40 cycles apart SHALL give PeriodOut=40 after the second edge; after the last edge plus 100 idle cycles, Active SHALL be 0 and PeriodOut SHALL still read 40.
REQ-035 An edge on the terminal cycle SHALL be counted in the closing window; Enable low for 30 cycles mid-window SHALL delay Update by exactly 30 cycles.
REQ-036 reset_n asserted mid-window SHALL zero all outputs immediately, and the first Update SHALL follow 100 cycles after release.

Source files
------------

// File: rtl/cadence_pkg.sv
// cadence_pkg: default parameters and per-channel status record shared by cadence_meter.
package cadence_pkg;
    localparam int unsigned DEF_NUM_CH          = 2;
    localparam int unsigned DEF_WINDOW_CYCLES   = 100_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;
    localparam int unsigned DEF_CNT_W           = 8;
    localparam int unsigned DEF_PERIOD_W        = 27;
    localparam int unsigned STAT_W              = 32;

    // Fields are sized for the widest legal configuration; users take the low bits.
    typedef struct packed {
        logic [STAT_W-1:0] count;
        logic [STAT_W-1:0] period;
        logic              active;
    } ch_status_t;

    function automatic int unsigned cw(input int unsigned n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cadence_channel.sv
// cadence_channel: one blip lane -- sync, debounce, edge detect, window count, period and timeout.
module cadence_channel
    import cadence_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned PERIOD_W        = DEF_PERIOD_W
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       term_i,
    input  logic       blip_i,
    output ch_status_t status_o
);
    localparam int unsigned   DW    = cw(DEBOUNCE_CYCLES);
    localparam int unsigned   TW    = cw(WINDOW_CYCLES);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TLAST = TW'(WINDOW_CYCLES - 1);

    logic [1:0]          sync_q;
    logic                deb_q, deb_d, seen_q, act_q, act_d, rise, tmo_hit;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]    run_q, run_d, run_inc, count_q, count_d;
    logic [PERIOD_W-1:0] per_q, per_d, per_inc, period_q, period_d;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (en_i && DEBOUNCE_CYCLES == 0) begin
            deb_d = sync_q[1];
        end else if (en_i) begin
            dcnt_d = (sync_q[1] != deb_q && dcnt_q != DLAST) ? dcnt_q + 1'b1 : '0;
            deb_d  = (sync_q[1] != deb_q && dcnt_q == DLAST) ? sync_q[1] : deb_q;
        end
    end

    // deb_d only moves while enabled, so rise is already gated by en_i.
    always_comb begin
        rise     = deb_d & ~deb_q;
        run_inc  = (rise && run_q != '1) ? run_q + 1'b1 : run_q;
        run_d    = term_i ? '0 : run_inc;
        count_d  = term_i ? run_inc : count_q;
        per_inc  = (per_q != '1) ? per_q + 1'b1 : per_q;
        per_d    = !en_i ? per_q : rise ? '0 : per_inc;
        period_d = (rise && seen_q) ? per_inc : period_q;
        tmo_hit  = en_i && act_q && tmo_q == TLAST;
        tmo_d    = (rise || tmo_hit) ? '0 : (en_i && act_q) ? tmo_q + 1'b1 : tmo_q;
        act_d    = rise || (act_q && !tmo_hit);
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            deb_q    <= 1'b0;
            dcnt_q   <= '0;
            run_q    <= '0;
            count_q  <= '0;
            per_q    <= '0;
            period_q <= '0;
            seen_q   <= 1'b0;
            act_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], blip_i};
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            run_q    <= run_d;
            count_q  <= count_d;
            per_q    <= per_d;
            period_q <= period_d;
            seen_q   <= seen_q | rise;
            act_q    <= act_d;
            tmo_q    <= tmo_d;
        end
    end

    assign status_o = '{count: STAT_W'(count_q), period: STAT_W'(period_q), active: act_q};
endmodule

// File: rtl/cadence_meter.sv
// cadence_meter: multi-channel blip rate meter with a shared gate window and per-lane status.
module cadence_meter
    import cadence_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned PERIOD_W        = DEF_PERIOD_W
) (
    input  logic                       clk50M,
    input  logic                       reset_n,
    input  logic                       Enable,
    input  logic [NUM_CH-1:0]          Blips,
    output logic [NUM_CH*CNT_W-1:0]    CountOut,
    output logic [NUM_CH*PERIOD_W-1:0] PeriodOut,
    output logic [NUM_CH-1:0]          Active,
    output logic                       Update
);
    localparam int unsigned   TW    = cw(WINDOW_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(WINDOW_CYCLES - 1);

    logic [TW-1:0]     timer_q, timer_d;
    logic              term, update_q;
    ch_status_t        st [NUM_CH];
    logic [NUM_CH-1:0] unused_st;

    always_comb begin
        term    = Enable && timer_q == TLAST;
        timer_d = !Enable ? timer_q : term ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            timer_q  <= '0;
            update_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            update_q <= term;
        end
    end

    assign Update = update_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cadence_channel #(
            .WINDOW_CYCLES  (WINDOW_CYCLES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .PERIOD_W       (PERIOD_W)
        ) u_ch (
            .clk50M  (clk50M),
            .reset_n (reset_n),
            .en_i    (Enable),
            .term_i  (term),
            .blip_i  (Blips[g]),
            .status_o(st[g])
        );
        assign CountOut[g*CNT_W +: CNT_W]        = st[g].count[CNT_W-1:0];
        assign PeriodOut[g*PERIOD_W +: PERIOD_W] = st[g].period[PERIOD_W-1:0];
        assign Active[g]                         = st[g].active;
        assign unused_st[g]                      = ^st[g];
    end
endmodule

// File: tb/tb_cadence_meter.sv
// tb_cadence_meter: directed and random blip traffic checked against an edge-timestamp model.
module tb_cadence_meter;
    localparam int NCH = 2;
    localparam int W   = 100;
    localparam int DEB = 4;
    localparam int CW  = 3;
    localparam int PW  = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic              clk50M = 1'b0;
    logic              reset_n;
    logic              Enable;
    logic [NCH-1:0]    Blips;
    logic [NCH*CW-1:0] CountOut;
    logic [NCH*PW-1:0] PeriodOut;
    logic [NCH-1:0]    Active;
    logic              Update;

    cadence_meter #(
        .NUM_CH(NCH), .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .PERIOD_W(PW)
    ) dut (
        .clk50M(clk50M), .reset_n(reset_n), .Enable(Enable), .Blips(Blips),
        .CountOut(CountOut), .PeriodOut(PeriodOut), .Active(Active), .Update(Update)
    );

    always #5 clk50M = ~clk50M;

    int unsigned ecyc;
    int unsigned q_edge [NCH][$];
    int unsigned run [NCH], m_cnt [NCH], m_per [NCH], last [NCH];
    bit          seen [NCH];
    bit          m_upd;
    int          n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0d expected=%0d at ecyc=%0d", tag, got, exp, ecyc);
        else n_pass++;
    endtask

    // Accepted edges are timestamps in enabled cycles; windows close every W enabled cycles.
    task automatic model_step();
        if (!reset_n) begin
            ecyc  = 0;
            m_upd = 0;
            for (int c = 0; c < NCH; c++) begin
                run[c] = 0; m_cnt[c] = 0; m_per[c] = 0; last[c] = 0; seen[c] = 0;
                q_edge[c].delete();
            end
        end else if (Enable) begin
            ecyc++;
            for (int c = 0; c < NCH; c++) begin
                if (q_edge[c].size() > 0 && q_edge[c][0] == ecyc) begin
                    void'(q_edge[c].pop_front());
                    if (run[c] < CMAX) run[c]++;
                    if (seen[c]) m_per[c] = (ecyc - last[c] > PMAX) ? PMAX : ecyc - last[c];
                    seen[c] = 1;
                    last[c] = ecyc;
                end
            end
            m_upd = (ecyc % W == 0);
            if (m_upd) for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = run[c];
                run[c]   = 0;
            end
        end else begin
            m_upd = 0;
        end
    endtask

    initial forever begin
        @(posedge clk50M or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk50M);
        if (reset_n === 1'b1) begin
            check("upd", 32'(Update), 32'(m_upd));
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("cnt%0d", c), 32'(CountOut[c*CW +: CW]), m_cnt[c]);
                check($sformatf("per%0d", c), 32'(PeriodOut[c*PW +: PW]), m_per[c]);
                check($sformatf("act%0d", c), 32'(Active[c]), 32'(seen[c] && (ecyc - last[c] < W)));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk50M);
        #1;
    endtask

    // Debounced edge lands DEB+2 enabled cycles after the raw rise.
    task automatic pulse(input logic [NCH-1:0] mask, input int w);
        for (int c = 0; c < NCH; c++)
            if (mask[c] && w >= DEB) q_edge[c].push_back(ecyc + DEB + 2);
        Blips = Blips | mask;
        tick(w);
        Blips = Blips & ~mask;
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while (ecyc % W != ph && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) check("phase_timeout", ecyc % W, ph);
    endtask

    task automatic cycles_to_update(output int n);
        n = 0;
        while (Update !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt"}, 32'(CountOut), 0);
        check({tag, "_per"}, 32'(PeriodOut), 0);
        check({tag, "_act"}, 32'(Active), 0);
        check({tag, "_upd"}, 32'(Update), 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        Enable  = 1'b0;
        Blips   = '0;
        #22;
        check_zero("rst");
        @(posedge clk50M);
        #1;
        reset_n = 1'b1;
        Enable  = 1'b1;

        repeat (5) begin
            pulse(2'b01, 6);
            tick(10);
        end
        wait_phase(0);
        check("r31_upd", 32'(Update), 1);
        check("r31_cnt0", 32'(CountOut[CW-1:0]), 5);
        check("r31_cnt1", 32'(CountOut[2*CW-1:CW]), 0);
        check("r31_per0", 32'(PeriodOut[PW-1:0]), 16);

        pulse(2'b01, 3);
        tick(8);
        pulse(2'b01, 5);
        tick(10);
        wait_phase(0);
        check("r32_cnt", 32'(CountOut[CW-1:0]), 1);

        repeat (10) begin
            pulse(2'b01, 5);
            tick(5);
        end
        wait_phase(0);
        check("r33_sat", 32'(CountOut[CW-1:0]), 7);
        tick(1);
        wait_phase(0);
        check("r33_next", 32'(CountOut[CW-1:0]), 0);

        pulse(2'b10, 5);
        tick(35);
        pulse(2'b10, 5);
        tick(5);
        check("r34_per", 32'(PeriodOut[2*PW-1:PW]), 40);
        check("r34_act_on", 32'(Active[1]), 1);
        tick(100);
        check("r34_act_off", 32'(Active[1]), 0);
        check("r34_per_hold", 32'(PeriodOut[2*PW-1:PW]), 40);

        wait_phase(W - DEB - 6);
        pulse(2'b01, 5);
        wait_phase(0);
        check("r35_term", 32'(CountOut[CW-1:0]), 1);
        wait_phase(50);
        Enable = 1'b0;
        tick(30);
        Enable = 1'b1;
        cycles_to_update(n);
        check("r35_delay", n + 30, 80);

        tick(1);
        wait_phase(40);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("r36_rst");
        tick(3);
        reset_n = 1'b1;
        cycles_to_update(n);
        check("r36_first_upd", n, 100);

        for (int i = 0; i < 80; i++) begin
            logic [NCH-1:0] m;
            int w, g;
            m = NCH'($urandom_range(1, 3));
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 10);
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(120, 300) : $urandom_range(5, 40);
            pulse(m, w);
            tick(g);
        end
        tick(150);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
